// File: rtl/ahb_arb_pkg.sv
// Shared types and defaults for the round-robin AHB arbiter.
package ahb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DefNumMasters   = 4;
  localparam int unsigned DefSelW         = 2;
  localparam int unsigned DefTimeoutCycles = 256;

  // An error response keeps the transfer open, so only an OKAY with ready completes it.
  function automatic logic tr_done(input logic hready_out, input logic hresp);
    return hready_out & ~hresp;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority request picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MIDX_W      = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MIDX_W-1:0]      ptr_i,
  output logic [NUM_MASTERS-1:0] win_oh_o,
  output logic [MIDX_W-1:0]      win_idx_o,
  output logic                   any_o
);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [2*NUM_MASTERS-1:0] req_msk;

  // The upper copy is never masked, so wrap-around requests are still found there.
  always_comb begin
    req_dbl   = {req_i, req_i};
    req_msk   = '0;
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = |req_i;
    for (int j = 0; j < 2 * int'(NUM_MASTERS); j++) begin
      req_msk[j] = req_dbl[j] && (j >= int'(ptr_i));
    end
    for (int j = 2 * int'(NUM_MASTERS) - 1; j >= 0; j--) begin
      if (req_msk[j]) begin
        win_idx_o = MIDX_W'(j % int'(NUM_MASTERS));
      end
    end
    if (any_o) begin
      win_oh_o[win_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter with registered grant, select and master index.
// Optional bus-hold watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = DefNumMasters,
  parameter int unsigned SEL_W          = DefSelW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  localparam int unsigned MIDX_W        = $clog2(NUM_MASTERS)
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [NUM_MASTERS-1:0]       hreq,
  input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
  input  logic                         hready_out,
  input  logic                         hresp,
  output logic [NUM_MASTERS-1:0]       hgrant,
  output logic [SEL_W-1:0]             sel,
  output logic [MIDX_W-1:0]            hmaster,
  output logic                         busy,
  output logic                         timeout
);

  arb_state_e             state_q;
  logic [MIDX_W-1:0]      ptr_q;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [SEL_W-1:0]       sel_q;
  logic [MIDX_W-1:0]      hmaster_q;
  logic                   busy_q;
  logic                   timeout_q;

  logic [NUM_MASTERS-1:0] win_oh;
  logic [MIDX_W-1:0]      win_idx;
  logic                   any_req;
  logic [MIDX_W-1:0]      ptr_d;
  logic [SEL_W-1:0]       win_sel;
  logic [SEL_W-1:0]       owner_sel;
  logic                   done;
  logic                   expire;
  logic                   advance;
  logic                   take;
  logic                   release_bus;

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .MIDX_W     (MIDX_W)
  ) u_pick (
    .req_i    (hreq),
    .ptr_i    (ptr_q),
    .win_oh_o (win_oh),
    .win_idx_o(win_idx),
    .any_o    (any_req)
  );

  assign done    = tr_done(hready_out, hresp);
  assign advance = (state_q == ARB_GRANT) && (done || expire);
  assign take    = ((state_q == ARB_IDLE) || advance) && any_req;
  assign release_bus = advance && !any_req;

  always_comb begin
    win_sel   = sel_in[SEL_W*int'(win_idx) +: SEL_W];
    owner_sel = sel_in[SEL_W*int'(hmaster_q) +: SEL_W];
    ptr_d     = (win_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q;

  assign expire = (state_q == ARB_GRANT) && !done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (take || release_bus) begin
        cnt_q <= '0;
      end else if (state_q == ARB_GRANT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign expire    = 1'b0;
  assign timeout_q = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      hgrant_q  <= '0;
      sel_q     <= '0;
      hmaster_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (take) begin
            state_q   <= ARB_GRANT;
            ptr_q     <= ptr_d;
            hgrant_q  <= win_oh;
            sel_q     <= win_sel;
            hmaster_q <= win_idx;
            busy_q    <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (take) begin
            // Back-to-back handover: old grant bit drops at the same edge.
            ptr_q     <= ptr_d;
            hgrant_q  <= win_oh;
            sel_q     <= win_sel;
            hmaster_q <= win_idx;
          end else if (release_bus) begin
            state_q   <= ARB_IDLE;
            hgrant_q  <= '0;
            sel_q     <= '0;
            hmaster_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            sel_q <= owner_sel;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign hgrant  = hgrant_q;
  assign sel     = sel_q;
  assign hmaster = hmaster_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Parametrised AHB bus arbiter for NUM_MASTERS masters with rotating (round-robin) priority. It grants one master at a time and holds the grant until the selected slave completes the transfer. It forwards the granted master's slave-select code to the address/write-data muxes. It succeeds the fixed three-master arbiter and adds fair rotation, back-to-back re-arbitration, a master-index output and an optional bus-hold watchdog.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..16.
- SEL_W, 2: width of each master's slave-select code.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles. Only used when ARB_TIMEOUT_EN is defined.
- Derived constant MIDX_W = $clog2(NUM_MASTERS).

Ports (one clock; reset is asynchronous and active-low):
- hclk  in  1  bus clock; all state changes on its rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hreq  in  NUM_MASTERS  per-master bus request; bit i belongs to master i.
- sel_in  in  NUM_MASTERS*SEL_W  flattened slave-select codes; master i occupies bits [i*SEL_W +: SEL_W].
- hready_out  in  1  ready from the selected slave.
- hresp  in  1  response from the selected slave; 1 = error.
- hgrant  out  NUM_MASTERS  one-hot grant, or all zero.
- sel  out  SEL_W  slave-select code of the granted master.
- hmaster  out  MIDX_W  index of the granted master.
- busy  out  1  high while any grant is held.
- timeout  out  1  one-cycle watchdog pulse. Tied to 0 when ARB_TIMEOUT_EN is not defined.

## Operation
- tr_done = hready_out & ~hresp.
  - An error response (hresp=1) does not complete the transfer; the grant is held.
- FSM states:
  - IDLE → GRANT when any hreq bit is high.
  - GRANT → GRANT (new owner) on tr_done when any hreq bit is high.
  - GRANT → IDLE on tr_done when all hreq bits are low.
  - GRANT holds otherwise.
- Winner selection:
  - Scan starts at index ptr and wraps modulo NUM_MASTERS.
  - The first set hreq bit wins.
- Pointer update:
  - On every new grant, ptr ← (winner+1) mod NUM_MASTERS.
  - Wrap rule: winner NUM_MASTERS-1 gives ptr=0.
  - ptr resets to 0, so master 0 has the highest priority after reset.
- While in GRANT:
  - Deasserting hreq does not revoke the grant; the grant ends only on tr_done or timeout.
  - sel is re-registered every cycle from the owner's sel_in slice.
- In IDLE: hgrant=0, sel=0, hmaster=0, busy=0.
- Simultaneous requests resolve by the pointer only; there is no fixed tie-break.
- Out-of-range hreq bits do not exist; NUM_MASTERS sizes every vector exactly.

## Timing
- All outputs are registered.
- Reset values: hgrant=0, sel=0, hmaster=0, busy=0, timeout=0, state=IDLE, ptr=0.
- Reset asserted mid-transfer clears all outputs immediately, without waiting for a clock edge.
- Grant latency: hreq sampled high at edge k in IDLE → hgrant, sel, hmaster and busy are valid after edge k.
- Handover: tr_done sampled at edge m with another request pending → the new grant is valid after edge m.
  - There is no dead cycle; the old grant bit falls at the same edge.
- Release: tr_done sampled at edge m with no requests → all outputs are zero after edge m.
- The winner uses the hreq value sampled at the same edge as tr_done.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter clears on every new grant and increments each GRANT cycle without tr_done.
  - When the counter reaches TIMEOUT_CYCLES-1 without tr_done, the arbiter forces the same transition as tr_done (handover or release).
  - timeout pulses high for exactly one cycle after that edge.
  - tr_done in the same cycle takes precedence: the transition is taken and no timeout pulse is issued.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout is constant 0.
  - A grant can be held indefinitely.

## Structure
- Package ahb_arb_pkg:
  - state enum {ARB_IDLE, ARB_GRANT}.
  - Default parameter constants.
  - tr_done helper function.
- Sub-module rr_pick:
  - Combinational; inputs are the request vector and ptr.
  - Outputs are a one-hot winner, the winner index and an any-request flag.
  - Implemented as a doubled-vector masked priority encoder.
- Top module: FSM, ptr register, output registers and the optional watchdog.

## Test plan
- Reset and single request (NUM_MASTERS=4): hreq=4'b0100 with sel_in slice 2 = 2'b11 → after one edge hgrant=4'b0100, hmaster=2, sel=2'b11, busy=1.
  - Asserting hresetn=0 mid-grant → all outputs 0 immediately.
- Round-robin fairness: hreq=4'b1111 held, tr_done every 3rd cycle → grants in the order 0,1,2,3,0, with no idle cycle between owners.
- Error hold: owner 1 with hready_out=1, hresp=1 for 5 cycles → hgrant stays 4'b0010.
  - Then hresp=0 with hreq=0 → all outputs 0 after the next edge.
- Pointer wrap and drop: owner 3 completes while hreq=4'b1001 → the grant goes to master 0.
  - Master 0 drops hreq during its grant → the grant is held until tr_done.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): owner 0 with hready_out=0 → the grant is released after 8 GRANT cycles and timeout=1 for one cycle.
  - tr_done coinciding with the limit cycle → no timeout pulse.
